mc_mem_ctrl: RTL
================

// Module: mc_mem_ctrl
// PURPOSE
//  Memory access controller directly downstream of the multicycle MIPS main-decoder FSM.
//  - Consumes the decoder outputs irwrite, iord, memwrite and lb.
//  - Drives a unified instruction/data memory over a req/ack handshake.
//  - Owns the instruction register (IR) and the memory data register (MDR), including
//    lb/lbu byte extraction.
//  - Returns stall to the decoder, which must hold its state while stall=1.
// PARAMETERS
//  TIMEOUT   255  cycles in S_REQ without mem_ack before aborting with err (1..255)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high
//  irwrite     in   1   fetch request; on completion the result is written to IR
//  iord        in   1   data access; address comes from aluout
//  memwrite    in   1   write access (valid only with iord=1)
//  lb          in   2   00 word, 01 byte sign-extend, 10 byte zero-extend, 11 treated as word
//  pc          in   32  fetch address
//  aluout      in   32  data address
//  wd          in   32  store data (B register)
//  mem_req     out  1   request, held until mem_ack
//  mem_we      out  1   write enable, qualified by mem_req
//  mem_addr    out  32  byte address, passed unaligned
//  mem_wdata   out  32  write data
//  mem_rdata   in   32  read data, valid when mem_ack=1
//  mem_ack     in   1   one-cycle completion strobe
//  instr       out  32  IR contents
//  data        out  32  MDR contents, already extended
//  stall       out  1   hold the decoder FSM
//  err         out  1   sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  - access = irwrite | iord. If both are asserted, iord wins and irwrite is ignored.
//  - stall = access & (state != S_DONE). This is combinational so the decoder stalls in the
//    same cycle it requests.
//  - State machine:
//    - S_IDLE:
//      - If access: latch addr (iord ? aluout : pc), we = iord & memwrite, wdata = wd,
//        lb, dest = (iord ? MDR : IR).
//      - Clear the timeout counter and go to S_REQ.
//    - S_REQ:
//      - mem_req=1; the latched values drive mem_*.
//      - Input changes are ignored while in S_REQ.
//      - On mem_ack for a read:
//        - dest=IR: IR <= mem_rdata.
//        - dest=MDR: MDR <= ext(mem_rdata).
//      - On mem_ack for a write: IR and MDR are unchanged.
//      - On mem_ack: go to S_DONE.
//      - If no ack and count reaches TIMEOUT-1: set err, leave IR/MDR unchanged, go to S_DONE.
//      - Otherwise increment the counter.
//    - S_DONE:
//      - stall=0, so the decoder advances on this edge.
//      - Next state is S_IDLE unconditionally, even if access is still high.
//  - Latency: a zero-wait access takes 3 cycles (IDLE, REQ, DONE), with stall=1 for 2 cycles.
//    Each wait state adds 1 cycle.
//  - Byte extraction is big-endian on addr[1:0]:
//    - 0 -> rdata[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
//    - lb=01 sign-extends; lb=10 zero-extends; 00 and 11 give the full word.
//  - mem_ack outside S_REQ is ignored.
//  - A late ack after a timeout is ignored.
//  - Reset values:
//    - state = S_IDLE; mem_req, mem_we, err = 0.
//    - mem_addr, mem_wdata, instr, data = 0.
//  - Reset mid-access: mem_req drops asynchronously and the access is abandoned (no retry).
//  - IR and MDR hold their values between writes.
// STRUCTURE
//  - Package mc_mem_pkg:
//    - enum logic [1:0] memstate_t {S_IDLE, S_REQ, S_DONE}.
//    - Constants LB_WORD=2'b00, LB_SEXT=2'b01, LB_ZEXT=2'b10.
//  - Sub-module mc_byte_ext: combinational (rdata[31:0], off[1:0], lb[1:0]) -> ext[31:0].
//  - Top level holds: the FSM, the 8-bit timeout counter, the request latches, IR and MDR.
// TESTING
//  1. Fetch, zero wait:
//     - Stimulus: irwrite=1, pc=0x00400000; ack in the first REQ cycle, rdata=0x8C080004.
//     - Response: mem_addr=0x00400000, instr=0x8C080004, stall high for 2 cycles.
//  2. lb, then lbu:
//     - Stimulus: aluout=0x10000001, rdata=0x12F45678.
//     - Response: lb gives data=0xFFFFFFF4; lbu gives data=0x000000F4; instr unchanged.
//  3. sw with 3 wait states:
//     - Stimulus: iord=1, memwrite=1, wd=0xDEADBEEF.
//     - Response: mem_we=1 and mem_wdata stable for 4 REQ cycles; stall high for 5 cycles;
//       MDR unchanged.
//  4. Timeout with TIMEOUT=4 and no ack:
//     - Response: mem_req high for exactly 4 cycles, then err=1 and S_DONE.
//     - A late ack is ignored; err stays 1 until reset.
//  5. Reset during S_REQ:
//     - Response: mem_req=0 immediately; instr=0, data=0.
//     - A following fetch completes normally.
//  6. Back-to-back lw then fetch:
//     - Response: S_DONE -> S_IDLE -> S_REQ.
//     - The second access is latched from the new inputs; no request is merged or lost.

Source files
------------

// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multicycle memory access controller.
package mc_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } memstate_t;

  localparam logic [1:0] LB_WORD = 2'b00;
  localparam logic [1:0] LB_SEXT = 2'b01;
  localparam logic [1:0] LB_ZEXT = 2'b10;

endpackage

// File: rtl/mc_byte_ext.sv
// Big-endian byte selection with sign/zero extension for lb/lbu loads.
module mc_byte_ext
  import mc_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  lb,
  output logic [31:0] ext
);

  logic [7:0] byte_sel;

  // Pick the addressed byte (offset 0 is the most significant byte), then extend.
  always_comb begin
    byte_sel = rdata[31:24];
    case (off)
      2'd0: byte_sel = rdata[31:24];
      2'd1: byte_sel = rdata[23:16];
      2'd2: byte_sel = rdata[15:8];
      2'd3: byte_sel = rdata[7:0];
      default: byte_sel = rdata[31:24];
    endcase
    case (lb)
      LB_SEXT: ext = {{24{byte_sel[7]}}, byte_sel};
      LB_ZEXT: ext = {24'h000000, byte_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mc_mem_ctrl.sv
// Memory access controller: turns decoder fetch/data requests into a req/ack
// memory transaction, owns IR and MDR, and stalls the decoder until done.
module mc_mem_ctrl
  import mc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irwrite,
  input  logic        iord,
  input  logic        memwrite,
  input  logic [1:0]  lb,
  input  logic [31:0] pc,
  input  logic [31:0] aluout,
  input  logic [31:0] wd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instr,
  output logic [31:0] data,
  output logic        stall,
  output logic        err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  memstate_t   state;
  logic [7:0]  cnt;
  logic [1:0]  lb_q;
  logic        dest_mdr;
  logic        access;
  logic [31:0] ext;

  assign access = irwrite | iord;

  // Combinational so the decoder holds in the very cycle it raises a request.
  assign stall = access & (state != S_DONE);

  mc_byte_ext u_ext (
    .rdata (mem_rdata),
    .off   (mem_addr[1:0]),
    .lb    (lb_q),
    .ext   (ext)
  );

  // Access FSM; the request latches double as the registered mem_* outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lb_q      <= LB_WORD;
      dest_mdr  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instr     <= '0;
      data      <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            mem_addr  <= iord ? aluout : pc;
            mem_we    <= iord & memwrite;
            mem_wdata <= wd;
            lb_q      <= lb;
            dest_mdr  <= iord;
            cnt       <= '0;
            mem_req   <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              if (dest_mdr) data  <= ext;
              else          instr <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_DONE;
          end else if (cnt == TO_LAST) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
